// File: rtl/fixed_abs_max_tree_pipelined.sv
// rtl/fixed_abs_max_tree_pipelined.sv - pipelined abs-max reduction tree with beat accumulator
// One registered compare layer per tree level, then a group accumulator feeding a holdable output.
module fixed_abs_max_tree_pipelined #(
  parameter int  IN_SIZE   = 4,
  parameter int  IN_WIDTH  = 16,
  parameter int  NUM_BEATS = 4,
  localparam int LAYERS    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 0,
  localparam int IDX_WIDTH = (IN_SIZE * NUM_BEATS > 1) ? $clog2(IN_SIZE * NUM_BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in [IN_SIZE-1:0],
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [IN_WIDTH-1:0]  data_out,
  output logic [IN_WIDTH-1:0]  data_out_abs,
  output logic [IDX_WIDTH-1:0] data_out_index,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);
  localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  // Element count of tree layer s: ceil(IN_SIZE / 2^s).
  function automatic int stage_cnt(input int s);
    return (IN_SIZE + (1 << s) - 1) >> s;
  endfunction

  logic en;
  assign en            = !data_out_valid || data_out_ready;
  assign data_in_ready = en;

  for (genvar s = 0; s <= LAYERS; s++) begin : g_stage
    localparam int N = stage_cnt(s);
    logic [IN_WIDTH-1:0]  v [N];
    logic [IN_WIDTH-1:0]  a [N];
    logic [IDX_WIDTH-1:0] x [N];
    logic                 vld;

    if (s == 0) begin : g_in
      assign vld = data_in_valid;
      for (genvar i = 0; i < N; i++) begin : g_lane
        assign v[i] = data_in[i];
        assign a[i] = data_in[i][IN_WIDTH-1] ? (~data_in[i] + IN_WIDTH'(1)) : data_in[i];
        assign x[i] = IDX_WIDTH'(i);
      end
    end else begin : g_reg
      localparam int P = stage_cnt(s - 1);

      always_ff @(posedge clk) begin
        if (rst)     vld <= 1'b0;
        else if (en) vld <= g_stage[s-1].vld;
      end

      // Lane i meets lane i+N of the previous layer; the odd leftover passes straight through.
      for (genvar i = 0; i < N; i++) begin : g_node
        if (i + N < P) begin : g_pair
          logic hi_wins;
          assign hi_wins = (g_stage[s-1].a[i+N] > g_stage[s-1].a[i]) ||
                           ((g_stage[s-1].a[i+N] == g_stage[s-1].a[i]) &&
                            (g_stage[s-1].x[i+N] < g_stage[s-1].x[i]));
          always_ff @(posedge clk) begin
            if (en) begin
              v[i] <= hi_wins ? g_stage[s-1].v[i+N] : g_stage[s-1].v[i];
              a[i] <= hi_wins ? g_stage[s-1].a[i+N] : g_stage[s-1].a[i];
              x[i] <= hi_wins ? g_stage[s-1].x[i+N] : g_stage[s-1].x[i];
            end
          end
        end else begin : g_pass
          always_ff @(posedge clk) begin
            if (en) begin
              v[i] <= g_stage[s-1].v[i];
              a[i] <= g_stage[s-1].a[i];
              x[i] <= g_stage[s-1].x[i];
            end
          end
        end
      end
    end
  end

  logic [IN_WIDTH-1:0]  t_val, t_abs;
  logic [IDX_WIDTH-1:0] t_idx, t_flat;
  logic                 t_vld;
  assign t_val = g_stage[LAYERS].v[0];
  assign t_abs = g_stage[LAYERS].a[0];
  assign t_idx = g_stage[LAYERS].x[0];
  assign t_vld = g_stage[LAYERS].vld;

  logic [BW-1:0]        beat_cnt;
  logic [IN_WIDTH-1:0]  acc_val, acc_abs, c_val, c_abs;
  logic [IDX_WIDTH-1:0] acc_idx, c_idx;
  logic                 last_beat, take_new;

  assign t_flat    = IDX_WIDTH'(beat_cnt) * IDX_WIDTH'(IN_SIZE) + t_idx;
  assign last_beat = (beat_cnt == BW'(NUM_BEATS - 1));
  // Strictly-greater keeps the earlier beat on a magnitude tie.
  assign take_new  = (beat_cnt == '0) || (t_abs > acc_abs);
  assign c_val     = take_new ? t_val  : acc_val;
  assign c_abs     = take_new ? t_abs  : acc_abs;
  assign c_idx     = take_new ? t_flat : acc_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt       <= '0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
      data_out_abs   <= '0;
      data_out_index <= '0;
    end else if (en) begin
      data_out_valid <= t_vld && last_beat;
      if (t_vld) begin
        if (last_beat) begin
          beat_cnt       <= '0;
          data_out       <= c_val;
          data_out_abs   <= c_abs;
          data_out_index <= c_idx;
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && t_vld && !last_beat) begin
      acc_val <= c_val;
      acc_abs <= c_abs;
      acc_idx <= c_idx;
    end
  end

endmodule

// File: tb/tb_fixed_abs_max_tree_pipelined.sv
// tb/tb_fixed_abs_max_tree_pipelined.sv - directed bench for fixed_abs_max_tree_pipelined
// Three instances share data lanes: NUM_BEATS=1 (a), 2 (b) and 4 (c).
module tb_fixed_abs_max_tree_pipelined;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din [3:0];

  logic        a_v, a_irdy, a_ov, a_ordy;
  logic [15:0] a_out, a_abs;
  logic [1:0]  a_idx;
  logic        b_v, b_irdy, b_ov, b_ordy;
  logic [15:0] b_out, b_abs;
  logic [2:0]  b_idx;
  logic        c_v, c_irdy, c_ov, c_ordy;
  logic [15:0] c_out, c_abs;
  logic [3:0]  c_idx;

  int errors = 0;
  int checks = 0;
  int nres   = 0;

  logic [15:0] exp_out [6];
  logic [15:0] exp_abs [6];
  logic [15:0] exp_idx [6];

  // Rows 0-11: three streamed groups; 12-19: two back-pressured groups; 20-21: partial; 22-25: post-reset.
  logic [15:0] cbeat [26][4] = '{
    '{16'd1, -16'sd2, 16'd3, -16'sd4}, '{16'd10, 16'd0, 16'd0, 16'd0},
    '{16'd0, 16'd0, 16'd0, -16'sd10},  '{16'd5, 16'd5, 16'd5, 16'd5},
    '{16'd0, 16'd0, 16'd0, 16'd0},     '{16'd0, 16'd0, 16'd0, 16'd0},
    '{16'd0, 16'd0, 16'd0, 16'd0},     '{16'd0, 16'd0, -16'sd1, 16'd0},
    '{16'h8000, 16'd0, 16'd0, 16'd0},  '{16'h7fff, 16'd0, 16'd0, 16'd0},
    '{16'd0, 16'd0, 16'd0, 16'd0},     '{16'd0, 16'd0, 16'd0, 16'h8000},
    '{16'd7, 16'd0, 16'd0, 16'd0},     '{16'd0, 16'd0, -16'sd20, 16'd0},
    '{16'd0, 16'd19, 16'd0, 16'd0},    '{16'd0, 16'd0, 16'd0, 16'd3},
    '{16'd100, 16'd0, 16'd0, 16'd0},   '{16'd0, 16'd0, 16'd0, 16'd0},
    '{16'd0, 16'd0, 16'd0, 16'd0},     '{16'd0, 16'd0, 16'd0, -16'sd101},
    '{-16'sd999, 16'd0, 16'd0, 16'd0}, '{16'd0, 16'd0, 16'd0, 16'd500},
    '{16'd1, 16'd0, 16'd0, 16'd0},     '{16'd0, 16'd2, 16'd0, 16'd0},
    '{16'd0, 16'd0, 16'd3, 16'd0},     '{16'd0, 16'd0, 16'd0, -16'sd4}
  };

  always #5 clk = ~clk;

  fixed_abs_max_tree_pipelined #(.IN_SIZE(4), .IN_WIDTH(16), .NUM_BEATS(1)) u_a (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(a_v), .data_in_ready(a_irdy),
    .data_out(a_out), .data_out_abs(a_abs), .data_out_index(a_idx),
    .data_out_valid(a_ov), .data_out_ready(a_ordy));

  fixed_abs_max_tree_pipelined #(.IN_SIZE(4), .IN_WIDTH(16), .NUM_BEATS(2)) u_b (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(b_v), .data_in_ready(b_irdy),
    .data_out(b_out), .data_out_abs(b_abs), .data_out_index(b_idx),
    .data_out_valid(b_ov), .data_out_ready(b_ordy));

  fixed_abs_max_tree_pipelined #(.IN_SIZE(4), .IN_WIDTH(16), .NUM_BEATS(4)) u_c (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(c_v), .data_in_ready(c_irdy),
    .data_out(c_out), .data_out_abs(c_abs), .data_out_index(c_idx),
    .data_out_valid(c_ov), .data_out_ready(c_ordy));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic beat(input logic [15:0] l0, input logic [15:0] l1,
                      input logic [15:0] l2, input logic [15:0] l3);
    din[0] = l0; din[1] = l1; din[2] = l2; din[3] = l3;
  endtask

  task automatic set_row(input int r);
    beat(cbeat[r][0], cbeat[r][1], cbeat[r][2], cbeat[r][3]);
  endtask

  task automatic c_collect();
    if (c_ov) begin
      if (nres < 6) begin
        chk($sformatf("c_res%0d_out", nres), c_out, exp_out[nres]);
        chk($sformatf("c_res%0d_abs", nres), c_abs, exp_abs[nres]);
        chk($sformatf("c_res%0d_idx", nres), 16'(c_idx), exp_idx[nres]);
      end else begin
        chk("c_extra_result", 16'(c_ov), 16'd0);
      end
      nres++;
    end
  endtask

  initial begin
    exp_out = '{16'd10, 16'hffff, 16'h8000, 16'hffec, 16'hff9b, 16'hfffc};
    exp_abs = '{16'd10, 16'd1,    16'h8000, 16'd20,   16'd101,  16'd4};
    exp_idx = '{16'd4,  16'd14,   16'd0,    16'd6,    16'd15,   16'd15};

    rst = 1'b1; a_v = 1'b0; b_v = 1'b0; c_v = 1'b0;
    a_ordy = 1'b1; b_ordy = 1'b1; c_ordy = 1'b1;
    beat(16'd0, 16'd0, 16'd0, 16'd0);
    tick(); tick();
    chk("rst_a_ov", 16'(a_ov), 16'd0);
    chk("rst_a_out", a_out, 16'd0);
    chk("rst_a_abs", a_abs, 16'd0);
    chk("rst_a_idx", 16'(a_idx), 16'd0);
    chk("rst_a_irdy", 16'(a_irdy), 16'd1);
    chk("rst_b_ov", 16'(b_ov), 16'd0);
    chk("rst_b_irdy", 16'(b_irdy), 16'd1);
    chk("rst_c_ov", 16'(c_ov), 16'd0);
    chk("rst_c_idx", 16'(c_idx), 16'd0);
    rst = 1'b0;

    // Single-beat groups: latency of three edges, then one result per cycle.
    beat(16'd3, -16'sd9, 16'd7, 16'd2); a_v = 1'b1; tick();
    a_v = 1'b0; tick();
    chk("t1_latency", 16'(a_ov), 16'd0);
    tick();
    chk("t1_valid", 16'(a_ov), 16'd1);
    chk("t1_out", a_out, 16'hfff7);
    chk("t1_abs", a_abs, 16'd9);
    chk("t1_idx", 16'(a_idx), 16'd1);
    tick();
    chk("t1_drop", 16'(a_ov), 16'd0);

    beat(16'd5, -16'sd5, 16'd0, 16'd0); a_v = 1'b1; tick();
    beat(16'h7fff, 16'h8000, 16'd0, 16'd1); tick();
    beat(16'd0, 16'd9, -16'sd9, 16'd0); tick();
    a_v = 1'b0;
    chk("t2_tie_out", a_out, 16'd5);
    chk("t2_tie_idx", 16'(a_idx), 16'd0);
    tick();
    chk("t3_ext_out", a_out, 16'h8000);
    chk("t3_ext_abs", a_abs, 16'h8000);
    chk("t3_ext_idx", 16'(a_idx), 16'd1);
    tick();
    chk("t2_xtie_valid", 16'(a_ov), 16'd1);
    chk("t2_xtie_out", a_out, 16'd9);
    chk("t2_xtie_idx", 16'(a_idx), 16'd1);

    // Two-beat groups: earlier beat wins a tie, strictly larger later beat replaces.
    beat(16'd0, 16'd0, 16'd8, 16'd0); b_v = 1'b1; tick();
    beat(-16'sd8, 16'd0, 16'd0, 16'd0); tick();
    beat(16'd1, 16'd2, 16'd3, 16'd4); tick();
    beat(16'd0, -16'sd100, 16'd0, 16'd0); tick();
    b_v = 1'b0;
    chk("t2_grp_valid", 16'(b_ov), 16'd1);
    chk("t2_grp_out", b_out, 16'd8);
    chk("t2_grp_abs", b_abs, 16'd8);
    chk("t2_grp_idx", 16'(b_idx), 16'd2);
    tick();
    chk("t2_grp_gap", 16'(b_ov), 16'd0);
    tick();
    chk("t2_grp2_out", b_out, 16'hff9c);
    chk("t2_grp2_idx", 16'(b_idx), 16'd5);

    // Four-beat streaming with bubbles inside groups.
    for (int k = 0; k < 12; k++) begin
      if (k == 2 || k == 5 || k == 6 || k == 9) begin
        c_v = 1'b0; tick(); c_collect();
      end
      set_row(k); c_v = 1'b1; tick(); c_collect();
    end
    c_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(); c_collect();
    end
    chk("t4_count", 16'(nres), 16'd3);

    // Back-pressure: result pending with ready low freezes everything.
    c_ordy = 1'b0;
    for (int k = 12; k < 18; k++) begin
      set_row(k); c_v = 1'b1; tick();
    end
    set_row(18);
    chk("t5_irdy_low", 16'(c_irdy), 16'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_hold_irdy", 16'(c_irdy), 16'd0);
      chk("t5_hold_ov", 16'(c_ov), 16'd1);
      chk("t5_hold_out", c_out, 16'hffec);
      chk("t5_hold_idx", 16'(c_idx), 16'd6);
    end
    c_collect();
    c_ordy = 1'b1; tick(); c_collect();
    set_row(19); tick(); c_collect();
    c_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(); c_collect();
    end
    chk("t5_count", 16'(nres), 16'd5);

    // Reset with two beats already in the accumulator.
    set_row(20); c_v = 1'b1; tick();
    set_row(21); tick();
    c_v = 1'b0; tick(); tick();
    rst = 1'b1; tick();
    chk("t6_rst_ov", 16'(c_ov), 16'd0);
    chk("t6_rst_out", c_out, 16'd0);
    chk("t6_rst_abs", c_abs, 16'd0);
    chk("t6_rst_idx", 16'(c_idx), 16'd0);
    chk("t6_rst_irdy", 16'(c_irdy), 16'd1);
    rst = 1'b0;
    for (int k = 22; k < 26; k++) begin
      set_row(k); c_v = 1'b1; tick(); c_collect();
    end
    c_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(); c_collect();
    end
    chk("t6_count", 16'(nres), 16'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
